// File: rtl/sargantana_icache_pkg.sv
// Shared defaults and packed way-array types for the I-cache hit pipeline.
// Types are sized for the default geometry; parameterised instances size their ports locally.
package sargantana_icache_pkg;

  localparam int unsigned N_WAY_DEF   = 4;
  localparam int unsigned TAG_W_DEF   = 20;
  localparam int unsigned LINE_W_DEF  = 256;
  localparam int unsigned FETCH_W_DEF = 128;
  localparam int unsigned CNT_W_DEF   = 32;

  typedef logic [N_WAY_DEF-1:0][TAG_W_DEF-1:0]   way_tags_t;
  typedef logic [N_WAY_DEF-1:0][LINE_W_DEF-1:0]  way_lines_t;
  typedef logic [N_WAY_DEF-1:0][FETCH_W_DEF-1:0] way_chunks_t;

endpackage

// File: rtl/sargantana_icache_prio_enc.sv
// Lowest-set-index priority encoder with any-set and multi-set flags; purely combinational.
// Multi-set uses the clear-lowest-bit trick: v & (v-1) is non-zero iff two or more bits are set.
module sargantana_icache_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         vec_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o,
  output logic                 multi_o
);

  localparam int unsigned IDX_W = $clog2(N);

  always_comb begin
    idx_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
    any_o   = |vec_i;
    multi_o = |(vec_i & (vec_i - N'(1)));
  end

endmodule

// File: rtl/sargantana_icache_hit_pipe.sv
// Two-stage I-cache hit pipeline: S1 compares tags and slices chunks, S2 picks the lowest hitting way.
// Latency 2, one lookup per cycle; rsp_ready_i low stalls S2 then S1 and deasserts req_ready_o.
module sargantana_icache_hit_pipe
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_WAY   = N_WAY_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned FETCH_W = FETCH_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  cnt_clr_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [TAG_W-1:0]                      req_tag_i,
  input  logic [$clog2(LINE_W/FETCH_W)-1:0]     req_idx_i,
  input  logic [N_WAY-1:0]                      way_valid_i,
  input  logic [N_WAY-1:0][TAG_W-1:0]           read_tags_i,
  input  logic [N_WAY-1:0][LINE_W-1:0]          data_rd_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic                                  rsp_hit_o,
  output logic [N_WAY-1:0]                      rsp_way_o,
  output logic [FETCH_W-1:0]                    rsp_data_o,
  output logic                                  rsp_multihit_o,
  output logic [CNT_W-1:0]                      hit_cnt_o,
  output logic [CNT_W-1:0]                      miss_cnt_o
);

  localparam int unsigned WSEL_W = $clog2(N_WAY);

  logic                            s1_valid_q, s1_valid_d;
  logic [N_WAY-1:0]                s1_hit_q, s1_hit_d;
  logic [N_WAY-1:0][FETCH_W-1:0]   s1_chunk_q, s1_chunk_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            rsp_hit_q, rsp_hit_d;
  logic [N_WAY-1:0]                rsp_way_q, rsp_way_d;
  logic [FETCH_W-1:0]              rsp_data_q, rsp_data_d;
  logic                            rsp_multihit_q, rsp_multihit_d;
  logic [CNT_W-1:0]                hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]                miss_cnt_q, miss_cnt_d;

  logic              s2_adv, s1_adv, accept, fire;
  logic [WSEL_W-1:0] sel_idx;
  logic              sel_any, sel_multi;

  sargantana_icache_prio_enc #(.N(N_WAY)) u_prio_enc (
    .vec_i   (s1_hit_q),
    .idx_o   (sel_idx),
    .any_o   (sel_any),
    .multi_o (sel_multi)
  );

  always_comb begin
    s2_adv      = !rsp_valid_q | rsp_ready_i;
    s1_adv      = !s1_valid_q | s2_adv;
    req_ready_o = s1_adv & !flush_i;
    accept      = req_valid_i & req_ready_o;
    fire        = rsp_valid_q & rsp_ready_i;

    s1_valid_d     = s1_valid_q;
    s1_hit_d       = s1_hit_q;
    s1_chunk_d     = s1_chunk_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_hit_d      = rsp_hit_q;
    rsp_way_d      = rsp_way_q;
    rsp_data_d     = rsp_data_q;
    rsp_multihit_d = rsp_multihit_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;

    if (s1_adv) s1_valid_d = accept;
    if (accept) begin
      for (int i = 0; i < int'(N_WAY); i++) begin
        s1_hit_d[i]   = (read_tags_i[i] == req_tag_i) & way_valid_i[i];
        s1_chunk_d[i] = data_rd_i[i][32'(req_idx_i) * FETCH_W +: FETCH_W];
      end
    end

    // Payload only moves when S1 holds a real lookup, so a drained S2 keeps its last response.
    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_hit_d      = sel_any;
        rsp_way_d      = s1_hit_q;
        rsp_multihit_d = sel_multi;
        rsp_data_d     = sel_any ? s1_chunk_q[sel_idx] : '0;
      end
    end

    if (flush_i) begin
      s1_valid_d  = 1'b0;
      rsp_valid_d = 1'b0;
    end

    if (cnt_clr_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (fire) begin
      if (rsp_hit_q) begin
        if (!(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end else begin
        if (!(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q     <= 1'b0;
      s1_hit_q       <= '0;
      s1_chunk_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_hit_q      <= 1'b0;
      rsp_way_q      <= '0;
      rsp_data_q     <= '0;
      rsp_multihit_q <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_hit_q       <= s1_hit_d;
      s1_chunk_q     <= s1_chunk_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_hit_q      <= rsp_hit_d;
      rsp_way_q      <= rsp_way_d;
      rsp_data_q     <= rsp_data_d;
      rsp_multihit_q <= rsp_multihit_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_hit_o      = rsp_hit_q;
  assign rsp_way_o      = rsp_way_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_multihit_o = rsp_multihit_q;
  assign hit_cnt_o      = hit_cnt_q;
  assign miss_cnt_o     = miss_cnt_q;

endmodule
